// File: rtl/dds_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dds_pkg
// Description : Constants and FSM state type shared by the DDS sample-path
//               blocks (DAC frame geometry and the SPI driver state set).
// Revision    : 1.0 - initial release
// ============================================================================
package dds_pkg;

    // DAC121S101 frame geometry: 12 data bits below 4 control bits
    localparam int         DAC_DATA_W    = 12;
    localparam int         DAC_FRAME_W   = 16;

    // Power-down control code for normal operation
    localparam logic [3:0] DAC_CTRL_BITS = 4'b0000;

    // SPI driver states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } dac_state_t;

endpackage
`default_nettype wire

// File: rtl/dac_spi_driver.sv
`default_nettype none
// ============================================================================
// Module      : dac_spi_driver
// Description : Accepts one offset-binary sample per valid/ready handshake and
//               shifts it MSB first as a 16-bit SPI frame into a
//               DAC121S101-class DAC. SCK idles high; the DAC samples MOSI on
//               the falling edge. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module dac_spi_driver
    import dds_pkg::*;
#(
    parameter int DATA_W   = DAC_DATA_W,
    parameter int FRAME_W  = DAC_FRAME_W,
    parameter int SCK_HALF = 1,
    parameter int CS_GAP   = 0
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              spi_sck,
    output logic              spi_mosi,
    output logic              spi_cs,
    output logic              busy,
    output logic              overrun
);

    localparam int c_BIT_W    = $clog2(FRAME_W);
    localparam int c_HALF_W   = $clog2(SCK_HALF + 1);
    localparam int c_GAP_W    = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam int c_GAP_LAST = (CS_GAP > 0) ? (CS_GAP - 1) : 0;

    localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(FRAME_W - 1);
    localparam logic [c_HALF_W-1:0] c_HALF_LAST = c_HALF_W'(SCK_HALF - 1);
    localparam logic [c_GAP_W-1:0]  c_GAP_END   = c_GAP_W'(c_GAP_LAST);

    if (SCK_HALF < 1) begin : g_bad_sck_half
        $error("dac_spi_driver: SCK_HALF must be at least 1");
    end

    dac_state_t           r_state_q,    w_state_d;
    logic [FRAME_W-1:0]   r_frame_q,    w_frame_d;
    logic [c_BIT_W-1:0]   r_bit_cnt_q,  w_bit_cnt_d;
    logic [c_HALF_W-1:0]  r_half_cnt_q, w_half_cnt_d;
    logic [c_GAP_W-1:0]   r_gap_cnt_q,  w_gap_cnt_d;
    logic                 r_sck_q,      w_sck_d;
    logic                 r_cs_q,       w_cs_d;
    logic                 r_mosi_q,     w_mosi_d;
    logic                 r_ready_q,    w_ready_d;
    logic                 r_busy_q,     w_busy_d;
    logic                 r_overrun_q,  w_overrun_d;

    logic [FRAME_W-1:0]   w_frame;
    logic [c_BIT_W-1:0]   w_bit_next;

    // Control bits sit above the sample; frame is held static and indexed by
    // the bit counter rather than shifted.
    assign w_frame    = FRAME_W'({DAC_CTRL_BITS, sample_in});
    assign w_bit_next = r_bit_cnt_q - c_BIT_W'(1);

    // Next-state and next-output logic for the IDLE/SHIFT/GAP sequencer
    always_comb begin
        w_state_d    = r_state_q;
        w_frame_d    = r_frame_q;
        w_bit_cnt_d  = r_bit_cnt_q;
        w_half_cnt_d = r_half_cnt_q;
        w_gap_cnt_d  = r_gap_cnt_q;
        w_sck_d      = r_sck_q;
        w_cs_d       = r_cs_q;
        w_mosi_d     = r_mosi_q;
        // A sample offered while not ready is dropped but remembered
        w_overrun_d  = r_overrun_q | (sample_valid & ~r_ready_q);

        case (r_state_q)
            IDLE: begin
                w_sck_d  = 1'b1;
                w_cs_d   = 1'b1;
                w_mosi_d = 1'b0;
                if (sample_valid) begin
                    w_state_d    = SHIFT;
                    w_frame_d    = w_frame;
                    w_bit_cnt_d  = c_BIT_LAST;
                    w_half_cnt_d = '0;
                    w_cs_d       = 1'b0;
                    w_mosi_d     = w_frame[FRAME_W-1];
                end
            end

            SHIFT: begin
                if (r_half_cnt_q == c_HALF_LAST) begin
                    w_half_cnt_d = '0;
                    if (r_sck_q) begin
                        // End of high half: falling edge, DAC samples MOSI
                        w_sck_d = 1'b0;
                    end else if (r_bit_cnt_q == '0) begin
                        // Low half of the last bit done: release SYNC
                        w_sck_d  = 1'b1;
                        w_cs_d   = 1'b1;
                        w_mosi_d = 1'b0;
                        if (CS_GAP > 0) begin
                            w_state_d   = GAP;
                            w_gap_cnt_d = '0;
                        end else begin
                            w_state_d   = IDLE;
                        end
                    end else begin
                        // Rising edge: present the next bit with it
                        w_bit_cnt_d = w_bit_next;
                        w_sck_d     = 1'b1;
                        w_mosi_d    = r_frame_q[w_bit_next];
                    end
                end else begin
                    w_half_cnt_d = r_half_cnt_q + c_HALF_W'(1);
                end
            end

            GAP: begin
                if (r_gap_cnt_q == c_GAP_END) begin
                    w_state_d = IDLE;
                end else begin
                    w_gap_cnt_d = r_gap_cnt_q + c_GAP_W'(1);
                end
            end

            default: begin
                w_state_d = IDLE;
                w_sck_d   = 1'b1;
                w_cs_d    = 1'b1;
                w_mosi_d  = 1'b0;
            end
        endcase

        // Ready and busy are registered copies of the next state
        w_ready_d = (w_state_d == IDLE);
        w_busy_d  = (w_state_d == SHIFT);
    end

    // State, counters and registered pin outputs; async active-low reset
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            r_state_q    <= IDLE;
            r_frame_q    <= '0;
            r_bit_cnt_q  <= '0;
            r_half_cnt_q <= '0;
            r_gap_cnt_q  <= '0;
            r_sck_q      <= 1'b1;
            r_cs_q       <= 1'b1;
            r_mosi_q     <= 1'b0;
            r_ready_q    <= 1'b0;
            r_busy_q     <= 1'b0;
            r_overrun_q  <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_frame_q    <= w_frame_d;
            r_bit_cnt_q  <= w_bit_cnt_d;
            r_half_cnt_q <= w_half_cnt_d;
            r_gap_cnt_q  <= w_gap_cnt_d;
            r_sck_q      <= w_sck_d;
            r_cs_q       <= w_cs_d;
            r_mosi_q     <= w_mosi_d;
            r_ready_q    <= w_ready_d;
            r_busy_q     <= w_busy_d;
            r_overrun_q  <= w_overrun_d;
        end
    end

    assign sample_ready = r_ready_q;
    assign spi_sck      = r_sck_q;
    assign spi_mosi     = r_mosi_q;
    assign spi_cs       = r_cs_q;
    assign busy         = r_busy_q;
    assign overrun      = r_overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_dac_spi_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_dac_spi_driver
// Description : Scoreboard bench for dac_spi_driver. Instance 0 uses default
//               timing, instance 1 uses SCK_HALF=3, CS_GAP=2. Expected frames
//               are queued at acceptance; a monitor decodes SPI frames from
//               the pins and compares against the queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_spi_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vld  [2];
    logic [11:0] din  [2];
    logic        rdy  [2];
    logic        sck  [2];
    logic        mosi [2];
    logic        cs   [2];
    logic        busy [2];
    logic        ovr  [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dac_spi_driver #(.DATA_W(12), .FRAME_W(16), .SCK_HALF(1), .CS_GAP(0)) u_dut0 (
        .sysclk(clk), .reset(rst_n), .sample_in(din[0]), .sample_valid(vld[0]),
        .sample_ready(rdy[0]), .spi_sck(sck[0]), .spi_mosi(mosi[0]),
        .spi_cs(cs[0]), .busy(busy[0]), .overrun(ovr[0])
    );

    dac_spi_driver #(.DATA_W(12), .FRAME_W(16), .SCK_HALF(3), .CS_GAP(2)) u_dut1 (
        .sysclk(clk), .reset(rst_n), .sample_in(din[1]), .sample_valid(vld[1]),
        .sample_ready(rdy[1]), .spi_sck(sck[1]), .spi_mosi(mosi[1]),
        .spi_cs(cs[1]), .busy(busy[1]), .overrun(ovr[1])
    );

    function automatic int sh(int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int gap(int i);
        return (i == 0) ? 0 : 2;
    endfunction

    task automatic check(string name, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
        end
    endtask

    // ---------------- scoreboard / monitor ----------------
    logic [15:0] exp0[$];
    logic [15:0] exp1[$];
    bit          in_fr     [2];
    logic [15:0] cap       [2];
    int          nb        [2];
    int          low_len   [2];
    int          last_fall [2];
    int          high_run  [2];
    int          last_gap  [2];
    int          falls     [2];
    bit          viol      [2];
    logic        prev_sck  [2];
    logic        prev_mosi [2];

    task automatic mon_step(int i);
        logic [15:0] e;
        bit          got;
        if (rst_n !== 1'b1) begin
            in_fr[i] = 0; high_run[i] = 0; viol[i] = 0; falls[i] = 0;
            prev_sck[i] = 1'b1; prev_mosi[i] = 1'b0;
            return;
        end
        if (cs[i] === 1'b0) begin
            if (!in_fr[i]) begin
                in_fr[i] = 1; low_len[i] = 0; nb[i] = 0; cap[i] = '0;
                last_fall[i] = -1; falls[i] = 0; last_gap[i] = high_run[i];
            end
            low_len[i]++;
            if (busy[i] !== 1'b1 || rdy[i] !== 1'b0) viol[i] = 1;
            if (prev_sck[i] === 1'b1 && sck[i] === 1'b0) begin
                cap[i] = {cap[i][14:0], mosi[i]};
                nb[i]++;
                falls[i]++;
                if (last_fall[i] >= 0 && (low_len[i] - last_fall[i]) != 2 * sh(i)) viol[i] = 1;
                last_fall[i] = low_len[i];
            end
            if (prev_sck[i] === 1'b0 && sck[i] === 1'b0 && mosi[i] !== prev_mosi[i]) viol[i] = 1;
        end else begin
            if (in_fr[i]) begin
                got = 0;
                e   = '0;
                if (i == 0 && exp0.size() > 0) begin e = exp0.pop_front(); got = 1; end
                if (i == 1 && exp1.size() > 0) begin e = exp1.pop_front(); got = 1; end
                if (!got) begin
                    total++; bad++;
                    $display("FAIL unexpected_frame%0d: got 0x%0h want none", i, cap[i]);
                end else begin
                    check($sformatf("frame%0d_data", i), cap[i], e);
                end
                check($sformatf("frame%0d_cs_low_len", i), low_len[i], 32 * sh(i));
                check($sformatf("frame%0d_falls", i), nb[i], 16);
                check($sformatf("frame%0d_protocol", i), viol[i], 0);
                check($sformatf("frame%0d_end_sck", i), sck[i], 1);
                in_fr[i] = 0; high_run[i] = 0; viol[i] = 0;
            end
            high_run[i]++;
            if (mosi[i] !== 1'b0 || busy[i] !== 1'b0 || sck[i] !== 1'b1) viol[i] = 1;
        end
        prev_sck[i]  = sck[i];
        prev_mosi[i] = mosi[i];
    endtask

    always begin
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) mon_step(i);
    end

    // ---------------- stimulus ----------------
    task automatic send(int i, logic [11:0] d, bit push);
        int k;
        k = 0;
        @(negedge clk);
        while (rdy[i] !== 1'b1) begin
            if (k == 500) begin
                total++; bad++;
                $display("FAIL send%0d_timeout: got ready=0 want ready=1", i);
                return;
            end
            k++;
            @(negedge clk);
        end
        din[i] = d;
        vld[i] = 1'b1;
        if (push) begin
            if (i == 0) exp0.push_back({4'b0000, d});
            else        exp1.push_back({4'b0000, d});
        end
        @(posedge clk);
        #1;
        vld[i] = 1'b0;
    endtask

    task automatic wait_ready(int i, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (rdy[i] !== 1'b1 && n < 2000);
        if (n >= 2000) check($sformatf("wait_ready%0d_timeout", i), 0, 1);
    endtask

    initial begin
        int n;
        int k;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            vld[i] = 1'b0;
            din[i] = '0;
        end

        // Reset values
        repeat (5) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst%0d_cs", i),    cs[i],   1);
            check($sformatf("rst%0d_sck", i),   sck[i],  1);
            check($sformatf("rst%0d_mosi", i),  mosi[i], 0);
            check($sformatf("rst%0d_ready", i), rdy[i],  0);
            check($sformatf("rst%0d_busy", i),  busy[i], 0);
            check($sformatf("rst%0d_ovr", i),   ovr[i],  0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready0_after_reset", rdy[0], 1);
        check("ready1_after_reset", rdy[1], 1);

        // Single frame and ready-return latency
        send(0, 12'hABC, 1);
        wait_ready(0, n);
        check("ready0_latency", n + 1, 1 + 16 * 2 * sh(0) + gap(0));

        // Back-to-back: second sample taken on the first IDLE cycle
        send(0, 12'h000, 1);
        send(0, 12'hFFF, 1);
        wait_ready(0, n);
        check("b2b_cs_high_gap", last_gap[0], 1);
        check("b2b_overrun", ovr[0], 0);

        // Overrun: offer 0x123 ten cycles into a 0x555 frame
        send(0, 12'h555, 1);
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("ovr_before_pulse", ovr[0], 0);
        din[0] = 12'h123;
        vld[0] = 1'b1;
        @(posedge clk);
        #1;
        vld[0] = 1'b0;
        check("ovr_set", ovr[0], 1);
        wait_ready(0, n);
        repeat (40) @(posedge clk);
        #1;
        check("ovr_sticky", ovr[0], 1);

        // Reset after the 7th falling edge of a frame
        send(0, 12'h7E7, 0);
        k = 0;
        do begin
            @(posedge clk);
            #2;
            k++;
        end while (falls[0] < 7 && k < 200);
        check("mid_reset_falls", falls[0], 7);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_reset_cs",   cs[0],   1);
        check("mid_reset_sck",  sck[0],  1);
        check("mid_reset_mosi", mosi[0], 0);
        check("mid_reset_ovr",  ovr[0],  0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send(0, 12'h3C3, 1);
        wait_ready(0, n);

        // Slow-clock instance with CS gap
        send(1, 12'h801, 1);
        wait_ready(1, n);
        check("ready1_latency", n + 1, 1 + 16 * 2 * sh(1) + gap(1));
        send(1, 12'($urandom), 1);
        wait_ready(1, n);
        check("gap1_cs_high", last_gap[1], 1 + gap(1));

        // Randomised traffic on both instances
        for (int j = 0; j < 24; j++) begin
            int i;
            i = int'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(i, 12'($urandom), 1);
        end
        wait_ready(0, n);
        wait_ready(1, n);
        repeat (120) @(posedge clk);
        #1;
        check("exp0_drained", exp0.size(), 0);
        check("exp1_drained", exp1.size(), 0);
        check("ovr1_clear", ovr[1], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
